dot_product: RTL
================

DOT_PRODUCT -- requirements
Module: dot_product

Interface
REQ-001 Parameter N, default 4: number of input elements per vector.
REQ-002 Parameter RATE, default 4: learning-rate right-shift applied to weight updates.
REQ-003 clk  input  1  the block's single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  training enable; when 1, the backward pass follows the forward pass.
REQ-006 arg_data  input  8  unsigned input element x[i], delivered in index order 0..N-1.
REQ-007 arg_valid  input  1 / arg_ready  output  1  ready/valid handshake for input elements.
REQ-008 res_data  output  16  signed Q8.8 weighted sum.
REQ-009 res_valid  output  1 / res_ready  input  1  handshake for the weighted sum.
REQ-010 err_data  input  16  signed Q8.8 error.
REQ-011 err_valid  input  1 / err_ready  output  1  handshake for the error.
REQ-012 fbk_data  output  16  signed Q8.8 back-propagated error for element i.
REQ-013 fbk_valid  output  1 / fbk_ready  input  1  handshake for the feedback beats.

Function
REQ-014 A transfer occurs on a rising edge where valid and ready are both high; a valid, once asserted, holds with stable data until its transfer completes.
REQ-015 The block holds N signed Q8.8 weights w[0..N-1] and N stored inputs x[0..N-1].
REQ-016 States: ARG, RES, ERR, FBK; the reset state is ARG.
REQ-017 ARG: arg_ready=1; each transfer stores x[i], adds x[i]*w[i] (signed, 32-bit accumulator) and increments i; transfer N-1 moves the block to RES.
REQ-018 RES: res_valid=1, res_data=sat16(acc>>>8); res_valid rises the cycle after the last arg transfer.
REQ-019 On the res transfer, en sampled 1 moves the block to ERR and en sampled 0 moves it to ARG; both clear acc and i.
REQ-020 ERR: err_ready=1; the err transfer latches err and moves the block to FBK with i=0.
REQ-021 FBK: fbk_valid=1, fbk_data=sat16((err*w[i])>>>8), computed from the pre-update weight.
REQ-022 Each fbk transfer commits w[i] <= sat16(w[i] + ((err*x[i])>>>(8+RATE))) and increments i; transfer N-1 returns the block to ARG.
REQ-023 Only one of arg_ready, res_valid, err_ready, fbk_valid is high in any cycle.
REQ-024 Arithmetic shifts floor toward negative infinity; sat16 clamps to [16'h8000, 16'h7FFF].
REQ-025 en is ignored outside the res transfer cycle.

Reset
REQ-026 While rst=0: state ARG, i=0, acc=0, err=0, all x=0, every w=16'h0100 (1.0), arg_ready=0, res_valid=0, err_ready=0, fbk_valid=0, res_data=0, fbk_data=0.
REQ-027 Reset asserted mid-operation discards all partial vectors and trained weights.
REQ-028 arg_ready rises on the first clock edge after rst deasserts.

Configuration
REQ-029 When DOT_PRODUCT_SAT_EN is defined, res_data, fbk_data and the weight update saturate as in REQ-018, REQ-021 and REQ-022.
REQ-030 When DOT_PRODUCT_SAT_EN is undefined, those three results truncate to the low 16 bits (two's-complement wrap), and all other behaviour is unchanged.

Verification
REQ-031 After reset, en=0, arg 1,2,3,4 -> res_data=16'h000A; err_ready never asserts; arg_ready returns.
REQ-032 en=1, arg 16,0,0,0 -> res 16'h0010; err 16'h1000 -> four fbk beats of 16'h1000; then fwd 16,0,0,0 -> res 16'h0011 (w0=16'h0110).
REQ-033 With SAT_EN defined, 16 training passes of arg 255,0,0,0 with err 16'h7FFF -> w0 clamps at 16'h7FFF; fwd 255,0,0,0 -> res 16'h7F7F.
REQ-034 res_ready held low 5 cycles in RES -> res_valid stays 1, res_data stays stable, arg_ready stays 0.
REQ-035 rst pulsed after 2 arg beats of a trained block -> all valid and ready outputs drop immediately; fwd 1,2,3,4 -> res 16'h000A.
REQ-036 fbk_ready toggled 1/0 every cycle during FBK -> exactly N beats, in index order, each weight updated exactly once.

Source files
------------

// File: rtl/dot_product.sv
// Trainable N-element dot product: streams x[i] in, returns sum(x*w) in Q8.8,
// then optionally takes an error and streams back err*w[i] while updating weights.
// Optional build macro: DOT_PRODUCT_SAT_EN (saturating results instead of wrapping).
module dot_product #(
  parameter int N    = 4,
  parameter int RATE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  arg_data,
  input  logic        arg_valid,
  output logic        arg_ready,
  output logic [15:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  input  logic [15:0] err_data,
  input  logic        err_valid,
  output logic        err_ready,
  output logic [15:0] fbk_data,
  output logic        fbk_valid,
  input  logic        fbk_ready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ARG, RES, ERR, FBK} state_t;

  state_t             state_q;
  logic [IW-1:0]      idx_q;
  logic signed [31:0] acc_q;
  logic signed [15:0] err_q;
  logic [7:0]         x_q [N];
  logic signed [15:0] w_q [N];
  logic               arg_ready_q;
  logic               res_valid_q;
  logic               err_ready_q;
  logic               fbk_valid_q;
  logic [15:0]        res_data_q;
  logic [15:0]        fbk_data_q;

  // Either clamps to the Q8.8 range or keeps the low 16 bits, depending on build.
  function automatic logic [15:0] sat16(input logic signed [31:0] v);
`ifdef DOT_PRODUCT_SAT_EN
    if (v > 32'sd32767)
      return 16'h7FFF;
    else if (v < -32'sd32768)
      return 16'h8000;
    else
      return v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  function automatic logic [15:0] fbkCalc(input logic signed [15:0] e,
                                          input logic signed [15:0] w);
    logic signed [31:0] eExt;
    logic signed [31:0] wExt;
    logic signed [31:0] prod;
    eExt = {{16{e[15]}}, e};
    wExt = {{16{w[15]}}, w};
    prod = eExt * wExt;
    return sat16(prod >>> 8);
  endfunction

  logic                lastIdx;
  logic [IW-1:0]       nextIdx;
  logic signed [24:0]  argExt;
  logic signed [24:0]  wArgExt;
  logic signed [24:0]  argProd;
  logic signed [31:0]  acc_d;
  logic signed [31:0]  accShift;
  logic signed [31:0]  errExt;
  logic signed [31:0]  xExt;
  logic signed [31:0]  errX;
  logic signed [31:0]  wCurExt;
  logic signed [31:0]  wSum;
  logic [15:0]         w_d;

  // Forward MAC for the incoming element and weight update for the element being fed back.
  always_comb begin
    lastIdx  = (idx_q == IW'(N - 1));
    nextIdx  = lastIdx ? '0 : idx_q + IW'(1);
    argExt   = {17'b0, arg_data};
    wArgExt  = {{9{w_q[idx_q][15]}}, w_q[idx_q]};
    argProd  = argExt * wArgExt;
    acc_d    = acc_q + {{7{argProd[24]}}, argProd};
    accShift = acc_d >>> 8;
    errExt   = {{16{err_q[15]}}, err_q};
    xExt     = {24'b0, x_q[idx_q]};
    errX     = (errExt * xExt) >>> (8 + RATE);
    wCurExt  = {{16{w_q[idx_q][15]}}, w_q[idx_q]};
    wSum     = wCurExt + errX;
    w_d      = sat16(wSum);
  end

  // Control and datapath state; every handshake output is a register so exactly one is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARG;
      idx_q       <= '0;
      acc_q       <= '0;
      err_q       <= '0;
      arg_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      err_ready_q <= 1'b0;
      fbk_valid_q <= 1'b0;
      res_data_q  <= '0;
      fbk_data_q  <= '0;
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        w_q[i] <= 16'sh0100;
      end
    end else begin
      case (state_q)
        ARG: begin
          arg_ready_q <= 1'b1;
          if (arg_ready_q && arg_valid) begin
            x_q[idx_q] <= arg_data;
            acc_q      <= acc_d;
            if (lastIdx) begin
              state_q     <= RES;
              arg_ready_q <= 1'b0;
              res_valid_q <= 1'b1;
              res_data_q  <= sat16(accShift);
            end else begin
              idx_q <= nextIdx;
            end
          end
        end
        RES: begin
          if (res_valid_q && res_ready) begin
            acc_q       <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            if (en) begin
              state_q     <= ERR;
              err_ready_q <= 1'b1;
            end else begin
              state_q     <= ARG;
              arg_ready_q <= 1'b1;
            end
          end
        end
        ERR: begin
          if (err_ready_q && err_valid) begin
            err_q       <= err_data;
            idx_q       <= '0;
            state_q     <= FBK;
            err_ready_q <= 1'b0;
            fbk_valid_q <= 1'b1;
            fbk_data_q  <= fbkCalc(err_data, w_q[0]);
          end
        end
        FBK: begin
          if (fbk_valid_q && fbk_ready) begin
            w_q[idx_q] <= w_d;
            if (lastIdx) begin
              idx_q       <= '0;
              state_q     <= ARG;
              fbk_valid_q <= 1'b0;
              arg_ready_q <= 1'b1;
            end else begin
              idx_q      <= nextIdx;
              fbk_data_q <= fbkCalc(err_q, w_q[nextIdx]);
            end
          end
        end
        default: state_q <= ARG;
      endcase
    end
  end

  assign arg_ready = arg_ready_q;
  assign res_valid = res_valid_q;
  assign err_ready = err_ready_q;
  assign fbk_valid = fbk_valid_q;
  assign res_data  = res_data_q;
  assign fbk_data  = fbk_data_q;

endmodule
